// File: rtl/map_object_scanner.sv
// Map object scanner: walks every map slot once per frame through the arbiter draw port
// and hands decoded, present objects to the draw stage over a valid/ready handshake.
module map_object_scanner #(
  parameter int unsigned NUM_SLOTS  = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned TIMEOUT    = 15,
  parameter int unsigned SKIP_EMPTY = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  output logic              read_req,
  output logic [ADDR_W-1:0] address0,
  input  logic              read_done,
  input  logic [31:0]       map_data,
  output logic              obj_valid,
  input  logic              obj_ready,
  output logic [ADDR_W-1:0] obj_index,
  output logic [2:0]        obj_type,
  output logic [7:0]        obj_x,
  output logic [7:0]        obj_y,
  output logic [11:0]       obj_value,
  output logic              busy,
  output logic              scan_done,
  output logic [ADDR_W:0]   obj_count,
  output logic              timeout_err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_PRESENT, S_NEXT, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [30:0]       word_q, word_d;
  logic              read_req_q, read_req_d;
  logic              obj_valid_q, obj_valid_d;
  logic              busy_q, busy_d;
  logic              scan_done_q, scan_done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tmo_err_q, tmo_err_d;

  logic keep_c, tmo_last_c, last_slot_c, accept_c;

  // Shared decode terms used by both next-state and output logic
  always_comb begin
    keep_c      = map_data[31] || (SKIP_EMPTY == 0);
    tmo_last_c  = (tmo_q == TMO_W'(TIMEOUT - 1));
    last_slot_c = (idx_q == ADDR_W'(NUM_SLOTS - 1));
    accept_c    = obj_valid_q && obj_ready;
  end

  // State and datapath registers; reset drops read_req immediately
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      tmo_q       <= '0;
      word_q      <= '0;
      read_req_q  <= 1'b0;
      obj_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      scan_done_q <= 1'b0;
      cnt_q       <= '0;
      tmo_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      word_q      <= word_d;
      read_req_q  <= read_req_d;
      obj_valid_q <= obj_valid_d;
      busy_q      <= busy_d;
      scan_done_q <= scan_done_d;
      cnt_q       <= cnt_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

  // Next-state logic; read_done wins over a coincident timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start) state_d = S_REQ;
      S_REQ:     state_d = S_WAIT;
      S_WAIT: begin
        if (read_done)       state_d = keep_c ? S_PRESENT : S_NEXT;
        else if (tmo_last_c) state_d = S_NEXT;
      end
      S_PRESENT: if (accept_c) state_d = S_NEXT;
      S_NEXT:    state_d = last_slot_c ? S_DONE : S_REQ;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Register updates per state
  always_comb begin
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    word_d      = word_q;
    read_req_d  = read_req_q;
    obj_valid_d = obj_valid_q;
    busy_d      = busy_q;
    scan_done_d = 1'b0;
    cnt_d       = cnt_q;
    tmo_err_d   = tmo_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d     = '0;
          cnt_d     = '0;
          tmo_err_d = 1'b0;
          busy_d    = 1'b1;
        end
      end
      S_REQ: begin
        read_req_d = 1'b1;
        tmo_d      = '0;
      end
      S_WAIT: begin
        if (read_done) begin
          word_d      = map_data[30:0];
          read_req_d  = 1'b0;
          obj_valid_d = keep_c;
        end else if (tmo_last_c) begin
          read_req_d = 1'b0;
          tmo_err_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_PRESENT: begin
        if (accept_c) begin
          obj_valid_d = 1'b0;
          if (cnt_q != CNT_W'(NUM_SLOTS)) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_NEXT: begin
        if (last_slot_c) scan_done_d = 1'b1;
        else             idx_d = idx_q + ADDR_W'(1);
      end
      S_DONE: busy_d = 1'b0;
      default: ;
    endcase
  end

  assign read_req    = read_req_q;
  assign address0    = idx_q;
  assign obj_valid   = obj_valid_q;
  assign obj_index   = idx_q;
  assign obj_type    = word_q[30:28];
  assign obj_x       = word_q[27:20];
  assign obj_y       = word_q[19:12];
  assign obj_value   = word_q[11:0];
  assign busy        = busy_q;
  assign scan_done   = scan_done_q;
  assign obj_count   = cnt_q;
  assign timeout_err = tmo_err_q;

endmodule
